alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_adder.sv | 27 ++
 rtl/alu.sv | 112 +++++++++++
 tb/tb_alu.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: the default operand width and the
// operation-select encoding used on the op port.
package alu_pkg;

    // Default operand/result width.
    localparam int ALU_WIDTH = 4;

    // Operation select codes (values are fixed by the op port encoding).
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NOT = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SLT = 3'b110,
        OP_EQ  = 3'b111
    } aluOp_e;

endpackage : alu_pkg

// File: rtl/alu_adder.sv
// Combinational WIDTH-bit adder with carry-in, carry-out and signed overflow.
// Subtraction and compare are done by the caller feeding ~y and an
// inverted carry-in, so this block only ever adds.
module alu_adder #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [WIDTH:0] fullSum;

    // Full-width sum; the extra top bit is the carry-out.
    always_comb begin
        fullSum = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    end

    assign sum_o  = fullSum[WIDTH-1:0];
    assign cout_o = fullSum[WIDTH];
    // Overflow: both addends share a sign and the result sign differs from it.
    assign ovf_o  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule : alu_adder

// File: rtl/alu.sv
// Single-cycle registered ALU. All operations are decoded combinationally
// and captured in one register stage together with the carry, zero and
// overflow flags.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic             in_c,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             zero,
    output logic             overflow
);

    aluOp_e           opSel;
    logic [WIDTH-1:0] adderB;
    logic             adderCin;
    logic [WIDTH-1:0] adderSum;
    logic             adderCout;
    logic             adderOvf;
    logic             lessThan;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d, carry_q;
    logic             zero_d, zero_q;
    logic             ovf_d, ovf_q;

    assign opSel = aluOp_e'(op);

    // Choose adder operands: ADD uses y and in_c directly; SUB and SLT add
    // ~y with an inverted borrow so the adder computes x - y - borrow.
    always_comb begin
        adderB   = ~in_y;
        adderCin = 1'b1;
        if (opSel == OP_ADD) begin
            adderB   = in_y;
            adderCin = in_c;
        end else if (opSel == OP_SUB) begin
            adderB   = ~in_y;
            adderCin = ~in_c;
        end
    end

    alu_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i    (in_x),
        .b_i    (adderB),
        .cin_i  (adderCin),
        .sum_o  (adderSum),
        .cout_o (adderCout),
        .ovf_o  (adderOvf)
    );

    // Signed x < y from x - y: the difference sign is correct unless the
    // subtraction overflowed, in which case it is inverted.
    assign lessThan = adderSum[WIDTH-1] ^ adderOvf;

    // Next-state result and flags; flags are cleared for non-arithmetic ops.
    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        case (opSel)
            OP_ADD: begin
                result_d = adderSum;
                carry_d  = adderCout;
                ovf_d    = adderOvf;
            end
            OP_SUB: begin
                result_d = adderSum;
                carry_d  = ~adderCout;
                ovf_d    = adderOvf;
            end
            OP_NOT:  result_d = ~in_x;
            OP_AND:  result_d = in_x & in_y;
            OP_OR:   result_d = in_x | in_y;
            OP_XOR:  result_d = in_x ^ in_y;
            OP_SLT:  result_d = WIDTH'(lessThan);
            OP_EQ:   result_d = WIDTH'(in_x == in_y);
            default: result_d = '0;
        endcase
        zero_d = (result_d == '0);
    end

    // Single register stage; synchronous reset clears every output.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_s    = result_q;
    assign out_c    = carry_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;

endmodule : alu

// File: tb/tb_alu.sv
// Scoreboard testbench for the ALU at WIDTH=4. Directed vectors with
// hand-computed results are driven on the falling edge; the expected
// response is queued at the same time and a monitor compares it against
// the registered outputs just after the next rising edge.
module tb_alu;

    typedef struct {
        string      name;
        logic [3:0] s;
        logic       c;
        logic       z;
        logic       v;
    } expect_t;

    logic       clk;
    logic       rst;
    logic [2:0] op;
    logic       in_c;
    logic [3:0] in_x;
    logic [3:0] in_y;
    logic [3:0] out_s;
    logic       out_c;
    logic       zero;
    logic       overflow;

    expect_t expQ[$];
    int      errorCount = 0;
    int      checkCount = 0;

    alu #(
        .WIDTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .in_c     (in_c),
        .in_x     (in_x),
        .in_y     (in_y),
        .out_s    (out_s),
        .out_c    (out_c),
        .zero     (zero),
        .overflow (overflow)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one vector on the falling edge and queue its expected response.
    task automatic applyStimulus(input string name, input logic r, input logic [2:0] o,
                                 input logic c, input logic [3:0] x, input logic [3:0] y,
                                 input logic [3:0] es, input logic ec, input logic ez,
                                 input logic ev);
        expect_t e;
        @(negedge clk);
        rst  = r;
        op   = o;
        in_c = c;
        in_x = x;
        in_y = y;
        e.name = name;
        e.s = es;
        e.c = ec;
        e.z = ez;
        e.v = ev;
        expQ.push_back(e);
    endtask

    // Compare the registered outputs against one queued expectation.
    task automatic checkOutput(input expect_t e);
        checkCount++;
        if (out_s !== e.s || out_c !== e.c || zero !== e.z || overflow !== e.v) begin
            errorCount++;
            $display("[TB] FAIL %s: got s=%h c=%b z=%b v=%b, expected s=%h c=%b z=%b v=%b",
                     e.name, out_s, out_c, zero, overflow, e.s, e.c, e.z, e.v);
        end
    endtask

    // Monitor: just after each rising edge, pop and check any pending expectation.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    // Directed stimulus, then a bounded drain of the scoreboard.
    initial begin
        bit drained;
        rst  = 1'b1;
        op   = 3'b000;
        in_c = 1'b0;
        in_x = 4'h0;
        in_y = 4'h0;
        repeat (2) @(posedge clk);

        //            name          rst op      c     x     y      s     c     z     v
        applyStimulus("reset_add",  1'b1, 3'b000, 1'b0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus("post_reset", 1'b0, 3'b000, 1'b0, 4'hF, 4'hF, 4'hE, 1'b1, 1'b0, 1'b0);
        applyStimulus("add_1_1",    1'b0, 3'b000, 1'b0, 4'h1, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0);
        applyStimulus("add_7_1",    1'b0, 3'b000, 1'b0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1);
        applyStimulus("add_F_1",    1'b0, 3'b000, 1'b0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus("add_cin",    1'b0, 3'b000, 1'b1, 4'h5, 4'h2, 4'h8, 1'b0, 1'b0, 1'b1);
        applyStimulus("sub_3_5",    1'b0, 3'b001, 1'b0, 4'h3, 4'h5, 4'hE, 1'b1, 1'b0, 1'b0);
        applyStimulus("sub_8_1",    1'b0, 3'b001, 1'b0, 4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b1);
        applyStimulus("sub_bin",    1'b0, 3'b001, 1'b1, 4'h5, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0);
        applyStimulus("sub_5_5",    1'b0, 3'b001, 1'b0, 4'h5, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus("sub_0_0_b",  1'b0, 3'b001, 1'b1, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
        applyStimulus("not_C",      1'b0, 3'b010, 1'b1, 4'hC, 4'hA, 4'h3, 1'b0, 1'b0, 1'b0);
        applyStimulus("and_C_A",    1'b0, 3'b011, 1'b1, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0);
        applyStimulus("or_C_A",     1'b0, 3'b100, 1'b1, 4'hC, 4'hA, 4'hE, 1'b0, 1'b0, 1'b0);
        applyStimulus("xor_C_A",    1'b0, 3'b101, 1'b1, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0, 1'b0);
        applyStimulus("not_F",      1'b0, 3'b010, 1'b0, 4'hF, 4'h3, 4'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus("slt_8_7",    1'b0, 3'b110, 1'b0, 4'h8, 4'h7, 4'h1, 1'b0, 1'b0, 1'b0);
        applyStimulus("slt_7_8",    1'b0, 3'b110, 1'b0, 4'h7, 4'h8, 4'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus("slt_3_3",    1'b0, 3'b110, 1'b1, 4'h3, 4'h3, 4'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus("slt_F_1",    1'b0, 3'b110, 1'b0, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
        applyStimulus("eq_5_5",     1'b0, 3'b111, 1'b0, 4'h5, 4'h5, 4'h1, 1'b0, 1'b0, 1'b0);
        applyStimulus("eq_5_4",     1'b0, 3'b111, 1'b0, 4'h5, 4'h4, 4'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus("reset_and",  1'b1, 3'b011, 1'b0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus("resume_sub", 1'b0, 3'b001, 1'b0, 4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b1);

        drained = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            if (expQ.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        if (!drained) begin
            errorCount++;
            checkCount++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule : tb_alu
